// File: rtl/pea_result_fifo.sv
// Result FIFO behind the polynomial evaluator: buffers {error, result} and serialises each entry as two 16-bit beats.
// Optional macro PEA_RES_DROP_ERR_EN discards entries strobed with error=0 and counts them in drop_cnt.
module pea_result_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [31:0]       result,
  input  logic              error,
  output logic              data_out_full,
  output logic [15:0]       out_data,
  output logic              out_err,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);
  // Handshake: a beat transfers on any cycle where out_valid && out_ready; while out_valid
  // is high and out_ready low, out_data/out_err/out_last are held unchanged.
  localparam int CNT_W = ADDR_W + 1;

  logic [32:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              beat_q, beat_d;
  logic              overflow_q, overflow_d;
  logic              keep, filt_drop, full, accept, push, pop;
  logic [32:0]       head;

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
`ifdef PEA_RES_DROP_ERR_EN
    keep      = write & error;
    filt_drop = write & ~error;
`else
    keep      = write;
    filt_drop = 1'b0;
`endif
    // Full is judged on the registered count, so a pop in the same cycle never frees the slot.
    push       = keep & ~full;
    accept     = out_valid & out_ready;
    pop        = accept & beat_q;
    wp_d       = push ? wp_q + ADDR_W'(1) : wp_q;
    rp_d       = pop ? rp_q + ADDR_W'(1) : rp_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    beat_d     = accept ? ~beat_q : beat_q;
    overflow_d = overflow_q | (keep & full);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      beat_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array carries no reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (reset && push) mem_q[wp_q] <= {error, result};
  end

`ifdef PEA_RES_DROP_ERR_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (filt_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) drop_cnt_q <= 8'd0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

  always_comb begin
    head     = mem_q[rp_q];
    out_data = 16'd0;
    out_err  = 1'b0;
    out_last = 1'b0;
    if (out_valid) begin
      out_data = beat_q ? head[15:0] : head[31:16];
      out_err  = head[32];
      out_last = beat_q;
    end
  end

  assign out_valid     = (count_q != '0);
  assign data_out_full = full;
  assign count         = count_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_pea_result_fifo.sv
// Self-checking bench for pea_result_fifo: directed table, hand sequences for full/overflow/reset corners, and
// randomized traffic against a queue-based reference model.
module tb_pea_result_fifo;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, write, error, out_ready;
  logic [31:0] result;
  logic        data_out_full, out_err, out_last, out_valid, overflow;
  logic [15:0] out_data;
  logic [3:0]  count;
  logic [7:0]  drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [32:0] mq[$];
  bit          m_beat;
  bit          m_ovf;
  int          m_drop;

  pea_result_fifo #(.DEPTH(DEPTH), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .write(write), .result(result), .error(error),
    .data_out_full(data_out_full), .out_data(out_data), .out_err(out_err),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance for one clock edge, from the rules: queue of entries, beat index, sticky overflow.
  task automatic model_step();
    bit keep, hs, was_full;
    if (!reset) begin
      mq.delete();
      m_beat = 0;
      m_ovf  = 0;
      m_drop = 0;
      return;
    end
`ifdef PEA_RES_DROP_ERR_EN
    keep = write && error;
    if (write && !error && m_drop < 255) m_drop++;
`else
    keep = write;
`endif
    was_full = (mq.size() == DEPTH);
    hs = (mq.size() != 0) && out_ready;
    if (keep && was_full) m_ovf = 1;
    if (hs) begin
      if (m_beat) void'(mq.pop_front());
      m_beat = !m_beat;
    end
    if (keep && !was_full) mq.push_back({error, result});
  endtask

  task automatic check_model();
    logic [32:0] h;
    logic [15:0] ed;
    bit v;
    v  = (mq.size() != 0);
    h  = v ? mq[0] : 33'd0;
    ed = !v ? 16'd0 : (m_beat ? h[15:0] : h[31:16]);
    chk("m_count", 32'(count), 32'(mq.size()));
    chk("m_valid", 32'(out_valid), 32'(v));
    chk("m_data", 32'(out_data), 32'(ed));
    chk("m_last", 32'(out_last), 32'(v && m_beat));
    chk("m_err", 32'(out_err), 32'(v && h[32]));
    chk("m_full", 32'(data_out_full), 32'(mq.size() == DEPTH));
    chk("m_ovf", 32'(overflow), 32'(m_ovf));
    chk("m_drop", 32'(drop_cnt), 32'(m_drop));
  endtask

  // Drive inputs, take one edge, then compare against the model 1 time unit later.
  task automatic apply(input logic rn, input logic w, input logic [31:0] r, input logic e, input logic rdy);
    reset = rn; write = w; result = r; error = e; out_ready = rdy;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic        rn, w;
    logic [31:0] res;
    logic        e, rdy;
    logic [3:0]  cnt;
    logic        vld;
    logic [15:0] dat;
    logic        lst, er_o, ovf;
  } vec_t;

  vec_t tbl[10];

  initial begin
    reset = 1'b0; write = 1'b0; result = '0; error = 1'b0; out_ready = 1'b0;

    // Directed table: single entry drain, then back-pressured negative value
    tbl[0] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 32'h1234_ABCD, 1'b1, 1'b1, 4'd1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'd1, 1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 4'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 4'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'd1, 1'b1, 16'hFFFB, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].rn, tbl[i].w, tbl[i].res, tbl[i].e, tbl[i].rdy);
      chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("t%0d_data", i), 32'(out_data), 32'(tbl[i].dat));
      chk($sformatf("t%0d_last", i), 32'(out_last), 32'(tbl[i].lst));
      chk($sformatf("t%0d_err", i), 32'(out_err), 32'(tbl[i].er_o));
      chk($sformatf("t%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
    end

    // Fill past capacity, then drain in order
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      apply(1'b1, 1'b1, 32'(k), 1'b1, 1'b0);
      if (k == 8) begin
        chk("fill_full8", 32'(data_out_full), 32'd1);
        chk("fill_ovf8", 32'(overflow), 32'd0);
      end
    end
    chk("fill_count9", 32'(count), 32'd8);
    chk("fill_ovf9", 32'(overflow), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      chk("drain_hi", 32'(out_data), 32'd0);
      apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("drain_lo", 32'(out_data), 32'(k));
      chk("drain_last", 32'(out_last), 32'd1);
      apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Write while full coinciding with the pop of the head
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) apply(1'b1, 1'b1, 32'h10 + 32'(k), 1'b1, 1'b0);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    apply(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("fullpop_count", 32'(count), 32'd7);
    chk("fullpop_ovf", 32'(overflow), 32'd1);
    chk("fullpop_head", 32'(out_data), 32'd0);

    // Reset in the middle of an entry
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("mid_last", 32'(out_last), 32'd1);
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    apply(1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
    chk("rst_beat0", 32'(out_data), 32'h0000);
    chk("rst_beat0_last", 32'(out_last), 32'd0);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("rst_beat1", 32'(out_data), 32'h0007);

    // Entry strobed with error=0
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
`ifdef PEA_RES_DROP_ERR_EN
    chk("errdrop_count", 32'(count), 32'd0);
    chk("errdrop_drop", 32'(drop_cnt), 32'd1);
    chk("errdrop_ovf", 32'(overflow), 32'd0);
`else
    chk("errkeep_count", 32'(count), 32'd1);
    chk("errkeep_err0", 32'(out_err), 32'd0);
    chk("errkeep_drop", 32'(drop_cnt), 32'd0);
    apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("errkeep_err1", 32'(out_err), 32'd0);
    chk("errkeep_last", 32'(out_last), 32'd1);
`endif

    // Randomized traffic against the model
    apply(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      apply(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 2) != 0),
            $urandom,
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pea_result_fifo.md
Name: pea_result_fifo

Overview:
Output stage directly downstream of the polynomial evaluator. It captures each 32-bit result and its error flag on the evaluator's `write` strobe and buffers them in a small FIFO. It drives `data_out_full` back to the evaluator's control unit as back-pressure. Each entry is serialised onto a 16-bit output bus as two beats, high half first, under a valid/ready handshake.

Parameters:
- DEPTH, 8, number of buffered entries; power of two, minimum 2.
- ADDR_W, 3, pointer width; must equal log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- write  input  1  evaluator result strobe; one entry is pushed per high cycle.
- result  input  32  signed evaluator result, sampled when write=1.
- error  input  1  evaluator status, sampled with result: 1 = valid result, 0 = evaluation error.
- data_out_full  output  1  high when count == DEPTH.
- out_data  output  16  current beat: result[31:16] on beat 0, result[15:0] on beat 1.
- out_err  output  1  error flag of the head entry; valid on both beats.
- out_last  output  1  high on beat 1 of an entry.
- out_valid  output  1  head entry present.
- out_ready  input  1  consumer accepts the current beat when out_valid and out_ready are both 1.
- count  output  ADDR_W+1  number of stored entries.
- overflow  output  1  sticky; set when a write is dropped.
- drop_cnt  output  8  count of entries discarded by the optional filter.

Behaviour:
- Reset (reset=0 at a clk edge):
  - All pointers, count, beat pointer, overflow and drop_cnt go to 0.
  - out_valid=0, out_last=0, out_data=0, out_err=0, data_out_full=0.
  - Reset mid-entry flushes all stored data; the next entry starts again at beat 0.
- Storage: circular buffer of {error, result[31:0]} with write pointer wp, read pointer rp and count.
  - Pointers wrap modulo DEPTH.
  - count is registered.
- Push: write=1 and count<DEPTH stores the entry at wp; wp increments.
- Write while full:
  - When write=1 and count==DEPTH, the entry is dropped and overflow is set to 1.
  - This holds even if the head is popped in the same cycle; full is judged on the registered count.
  - overflow clears only on reset.
- Output:
  - out_valid = (count != 0), combinational from registered state.
  - out_data, out_err and out_last are combinational from mem[rp] and the beat pointer.
  - The beat pointer is a 1-bit register.
- Latency: a push into an empty FIFO at edge N gives out_valid=1 from edge N until beat 0 is accepted (one cycle after the strobe cycle).
- Handshake:
  - While out_valid=1 and out_ready=0, out_data, out_err and out_last hold stable.
  - Beat 0 accepted: beat pointer goes to 1.
  - Beat 1 accepted: beat pointer goes to 0, rp increments and the entry is popped.
- Simultaneous push and pop with count<DEPTH: count is unchanged and both pointers advance.
- Simultaneous push and pop with count==DEPTH: the push is dropped (as above) and the pop proceeds, so count becomes DEPTH-1.
- Empty: out_valid=0 and out_ready is ignored. The beat pointer is always 0 when empty.
- data_out_full = (count == DEPTH), combinational from the registered count.
- No state machine beyond the beat pointer. Control is decided by count, the beat pointer and the handshake.

Optional Feature:
- Macro: PEA_RES_DROP_ERR_EN.
- Defined:
  - An entry strobed with error=0 is not stored and does not consume space.
  - drop_cnt increments, saturating at 255.
  - overflow is not affected by such a drop.
  - Entries with error=1 are handled normally.
- Undefined: every strobed entry is stored regardless of error, and drop_cnt is tied to 0.

Test Plan:
1. Reset, then write=1 for one cycle with result=32'h1234_ABCD, error=1, out_ready=1 → next cycle beat 0: out_data=16'h1234, out_err=1, out_last=0. Following cycle beat 1: out_data=16'hABCD, out_last=1. Then out_valid=0 and count=0.
2. Push result=-5, error=1 with out_ready=0 for 4 cycles → out_data=16'hFFFF held stable and out_valid=1 throughout. After out_ready=1, beat 1 shows out_data=16'hFFFB.
3. Hold out_ready=0 and push 9 entries with values 1..9 at DEPTH=8 → data_out_full=1 after the 8th push, the 9th is dropped, overflow=1 and count=8. Draining emits 1..8 in order.
4. Fill to count=8, then write=1 in the same cycle as the beat-1 accept → the push is dropped, overflow=1 and count=7.
5. Pull reset low after beat 0 of an entry has been accepted → the next cycle shows count=0, out_valid=0 and overflow=0. A new push of 32'h0000_0007 starts at beat 0 with out_data=16'h0000.
6. Push result=0, error=0 → with PEA_RES_DROP_ERR_EN: count stays 0 and drop_cnt=1. Without the macro: count=1, out_err=0 on both beats, and drop_cnt=0.
